gam_sample_feeder: RTL and testbench

Upstream input stage of the GAM memory layer. It accepts training samples as a serial stream of feature elements plus a class label, and assembles each sample into a `node_vector_T`. Complete samples are buffered in a small FIFO. The head sample is presented as the `x`/`c` operands to the memory-layer controller and datapath under a valid/ready handshake. This decouples the element-rate source from the multi-cycle learning sequence, which only consumes a new sample after finishing the previous one.

---
 rtl/gam_sample_feeder.sv | 156 +++++++++++++++
 tb/tb_gam_sample_feeder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gam_sample_feeder.sv
// Serial-to-vector sample assembler with a small sample FIFO feeding the GAM memory layer.
// Define GAM_FEEDER_LEN_CHECK_EN to check sample framing against in_last.
module gam_sample_feeder #(
    parameter int DIM    = 4,
    parameter int ELEM_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ELEM_W-1:0]              in_elem,
    input  logic                           in_last,
    input  logic [31:0]                    in_class,
    input  logic                           flush,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DIM-1:0][ELEM_W-1:0]     out_x,
    output logic [31:0]                    out_c,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic [15:0]                    sample_cnt,
    output logic                           err_len
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = (DIM > 1) ? $clog2(DIM) : 1;

    typedef logic [DIM-1:0][ELEM_W-1:0] vec_t;

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [EW-1:0] elem_cnt_q, elem_cnt_d;
    logic [15:0]   sample_cnt_q, sample_cnt_d;
    vec_t          staging_q, staging_d;
    vec_t          fifo_x_q [DEPTH];
    vec_t          fifo_x_d [DEPTH];
    logic [31:0]   fifo_c_q [DEPTH];
    logic [31:0]   fifo_c_d [DEPTH];

    logic beat, pop, push, last_pos, frame_ok;
    vec_t push_vec;

    assign in_ready   = (count_q != CW'(DEPTH));
    assign out_valid  = (count_q != '0);
    assign out_x      = out_valid ? fifo_x_q[rd_ptr_q] : '0;
    assign out_c      = out_valid ? fifo_c_q[rd_ptr_q] : '0;
    assign count      = count_q;
    assign sample_cnt = sample_cnt_q;

    always_comb begin
        beat     = in_valid && in_ready && !flush;
        pop      = out_valid && out_ready && !flush;
        last_pos = (elem_cnt_q == EW'(DIM - 1));
`ifdef GAM_FEEDER_LEN_CHECK_EN
        frame_ok = (in_last == last_pos);
`else
        frame_ok = 1'b1;
`endif
        push     = beat && last_pos && frame_ok;
        push_vec = staging_q;
        push_vec[elem_cnt_q] = in_elem;
    end

    // Assembly counter and staging vector; a framing error restarts at element 0.
    always_comb begin
        elem_cnt_d = elem_cnt_q;
        staging_d  = staging_q;
        if (flush) begin
            elem_cnt_d = '0;
        end else if (beat) begin
            staging_d[elem_cnt_q] = in_elem;
            if (last_pos || !frame_ok) begin
                elem_cnt_d = '0;
            end else begin
                elem_cnt_d = elem_cnt_q + EW'(1);
            end
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        sample_cnt_d = sample_cnt_q;
        fifo_x_d     = fifo_x_q;
        fifo_c_d     = fifo_c_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_x_d[wr_ptr_q] = push_vec;
                fifo_c_d[wr_ptr_q] = in_class;
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d     = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
                sample_cnt_d = sample_cnt_q + 16'd1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            elem_cnt_q   <= '0;
            sample_cnt_q <= '0;
        end else begin
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            elem_cnt_q   <= elem_cnt_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    // Storage is never read while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        staging_q <= staging_d;
        fifo_x_q  <= fifo_x_d;
        fifo_c_q  <= fifo_c_d;
    end

`ifdef GAM_FEEDER_LEN_CHECK_EN
    logic err_len_q, err_len_d;

    always_comb begin
        err_len_d = beat && !frame_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_len_q <= 1'b0;
        end else begin
            err_len_q <= err_len_d;
        end
    end

    assign err_len = err_len_q;
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign err_len        = 1'b0;
`endif

endmodule

// File: tb/tb_gam_sample_feeder.sv
// Directed scoreboard bench for gam_sample_feeder (DIM=4, DEPTH=4).
module tb_gam_sample_feeder;

    localparam int DIM   = 4;
    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int XW    = DIM * W;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [W-1:0]          in_elem;
    logic                  in_last;
    logic [31:0]           in_class;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [DIM-1:0][W-1:0] out_x;
    logic [31:0]           out_c;
    logic [2:0]            count;
    logic [15:0]           sample_cnt;
    logic                  err_len;

    gam_sample_feeder #(.DIM(DIM), .ELEM_W(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_elem    (in_elem),
        .in_last    (in_last),
        .in_class   (in_class),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_c      (out_c),
        .count      (count),
        .sample_cnt (sample_cnt),
        .err_len    (err_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XW-1:0] x;
        logic [31:0]   c;
    } smp_t;

    smp_t sb[$];
    int   pass_cnt  = 0;
    int   fail_cnt  = 0;
    int   total_cnt = 0;
    int   stall_cnt = 0;

    task automatic check(input string tag, input logic [XW-1:0] obs, input logic [XW-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scores any pop about to happen on the coming edge, then advances one cycle.
    task automatic tick();
        smp_t e;
        if (out_valid && out_ready && !flush && !rst) begin
            if (sb.size() == 0) begin
                check("pop_unexpected", XW'(out_valid), XW'(0));
            end else begin
                e = sb.pop_front();
                check("pop_x", out_x, e.x);
                check("pop_c", XW'(out_c), XW'(e.c));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_beat(input logic [W-1:0] v, input logic [31:0] c, input logic last);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_elem  = v;
        in_class = c;
        in_last  = last;
        for (int i = 0; i < 100 && !acc; i++) begin
            acc = in_ready;
            if (!acc) stall_cnt++;
            tick();
        end
        if (!acc) check("beat_timeout", XW'(acc), XW'(1));
    endtask

    function automatic logic [XW-1:0] mkvec(input logic [W-1:0] base);
        logic [XW-1:0] x;
        for (int k = 0; k < DIM; k++) x[k*W +: W] = base + W'(k);
        return x;
    endfunction

    task automatic send_sample(input logic [W-1:0] base, input logic [31:0] c);
        smp_t e;
        for (int k = 0; k < DIM; k++) send_beat(base + W'(k), c, (k == DIM - 1));
        e.x = mkvec(base);
        e.c = c;
        sb.push_back(e);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 200 && count != 3'd0; i++) tick();
        out_ready = 1'b0;
        check("drain_count", XW'(count), XW'(0));
    endtask

    initial begin
        smp_t e;
        rst = 1'b1; in_valid = 1'b0; in_elem = '0; in_last = 1'b0;
        in_class = '0; flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;

        check("rst_in_ready",   XW'(in_ready),   XW'(1));
        check("rst_out_valid",  XW'(out_valid),  XW'(0));
        check("rst_out_x",      out_x,           XW'(0));
        check("rst_out_c",      XW'(out_c),      XW'(0));
        check("rst_count",      XW'(count),      XW'(0));
        check("rst_sample_cnt", XW'(sample_cnt), XW'(0));
        check("rst_err_len",    XW'(err_len),    XW'(0));

        // First sample visible the cycle after its last beat.
        send_sample(32'd1, 32'd7);
        idle();
        check("t1_out_valid", XW'(out_valid), XW'(1));
        check("t1_out_x",     out_x,          mkvec(32'd1));
        check("t1_out_c",     XW'(out_c),     XW'(7));
        check("t1_count",     XW'(count),     XW'(1));

        // Fill, stall, pop once, drain in order.
        send_sample(32'd10, 32'd8);
        send_sample(32'd20, 32'd9);
        send_sample(32'd30, 32'd10);
        idle();
        check("full_count",    XW'(count),    XW'(4));
        check("full_in_ready", XW'(in_ready), XW'(0));
        in_valid = 1'b1; in_elem = 32'd99; in_class = 32'd11;
        tick(); tick(); tick();
        check("stall_count",    XW'(count),    XW'(4));
        check("stall_in_ready", XW'(in_ready), XW'(0));
        idle();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pop_in_ready", XW'(in_ready), XW'(1));
        check("pop_count",    XW'(count),    XW'(3));
        drain();
        check("fill_sample_cnt", XW'(sample_cnt), XW'(4));

        // Streaming with a continuously ready consumer.
        rst = 1'b1; tick(); rst = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        stall_cnt = 0;
        for (int i = 0; i < 20; i++) send_sample(32'd1000 + 32'(i * 16), 32'(100 + i));
        drain();
        check("stream_stalls",     XW'(stall_cnt),  XW'(0));
        check("stream_sample_cnt", XW'(sample_cnt), XW'(20));
        check("stream_sb_empty",   XW'(sb.size()),  XW'(0));

        // Flush mid-sample with three samples queued.
        send_sample(32'd40, 32'd1);
        send_sample(32'd44, 32'd2);
        send_sample(32'd48, 32'd3);
        send_beat(32'd50, 32'd4, 1'b0);
        send_beat(32'd51, 32'd4, 1'b0);
        idle();
        flush = 1'b1; tick(); flush = 1'b0;
        sb.delete();
        check("flush_count",      XW'(count),      XW'(0));
        check("flush_out_valid",  XW'(out_valid),  XW'(0));
        check("flush_sample_cnt", XW'(sample_cnt), XW'(20));
        send_sample(32'd60, 32'd3);
        idle();
        check("post_flush_x", out_x, mkvec(32'd60));
        drain();
        check("post_flush_sample_cnt", XW'(sample_cnt), XW'(21));

        // Push and pop on the same edge at count 2.
        send_sample(32'd200, 32'd1);
        send_sample(32'd210, 32'd2);
        check("pp_count_before", XW'(count), XW'(2));
        for (int k = 0; k < DIM - 1; k++) send_beat(32'd220 + 32'(k), 32'd3, 1'b0);
        out_ready = 1'b1;
        send_beat(32'd223, 32'd3, 1'b1);
        e.x = mkvec(32'd220); e.c = 32'd3; sb.push_back(e);
        out_ready = 1'b0;
        idle();
        check("pp_count_after", XW'(count), XW'(2));
        check("pp_head_x",      out_x,      mkvec(32'd210));
        check("pp_head_c",      XW'(out_c), XW'(2));
        drain();
        check("pp_sample_cnt", XW'(sample_cnt), XW'(24));

`ifdef GAM_FEEDER_LEN_CHECK_EN
        // Early in_last drops the partial sample.
        send_beat(32'd300, 32'd5, 1'b0);
        send_beat(32'd301, 32'd5, 1'b1);
        idle();
        check("early_last_err",   XW'(err_len), XW'(1));
        check("early_last_count", XW'(count),   XW'(0));
        tick();
        check("err_pulse_clear", XW'(err_len), XW'(0));
        // Missing in_last on the final element drops the sample.
        for (int k = 0; k < DIM; k++) send_beat(32'd305 + 32'(k), 32'd5, 1'b0);
        idle();
        check("missing_last_err",   XW'(err_len), XW'(1));
        check("missing_last_count", XW'(count),   XW'(0));
        send_sample(32'd310, 32'd5);
        idle();
        check("reframe_count", XW'(count), XW'(1));
        check("reframe_x",     out_x,       mkvec(32'd310));
        drain();
        check("len_sample_cnt", XW'(sample_cnt), XW'(25));
`else
        // in_last is ignored: framing is purely by element count.
        send_beat(32'd300, 32'd5, 1'b0);
        send_beat(32'd301, 32'd5, 1'b1);
        send_beat(32'd302, 32'd5, 1'b0);
        send_beat(32'd303, 32'd5, 1'b0);
        e.x = mkvec(32'd300); e.c = 32'd5; sb.push_back(e);
        idle();
        check("nolen_err",   XW'(err_len), XW'(0));
        check("nolen_count", XW'(count),   XW'(1));
        drain();
        check("nolen_sample_cnt", XW'(sample_cnt), XW'(25));
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
